xpb_lut_arbiter: RTL

Shares one registered xpb lookup table (5-bit digit in, 1024-bit precomputed residue out, one-cycle latency) among NUM_REQ reduction lanes of the modular-squaring datapath. Requesters present digits over valid/ready handshakes. The block grants one per cycle round-robin, drives the table, and tags and buffers each looked-up value. It returns results in issue order over a single backpressured response port.

---
 rtl/xpb_pkg.sv | 18 +
 rtl/xpb_rsp_fifo.sv | 51 +++++
 rtl/xpb_lut_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/xpb_pkg.sv
// Shared definitions for the xpb lookup-table arbiter.
// Holds the table geometry, the default lane count, the response buffer depth and the
// {id, data} response entry carried through the response buffer.
package xpb_pkg;

  localparam int unsigned DigitW        = 5;
  localparam int unsigned WordW         = 1024;
  localparam int unsigned NumReqDefault = 4;
  // Widest tag needed for the largest supported lane count (8).
  localparam int unsigned IdMaxW        = 3;
  localparam int unsigned RspDepth      = 2;

  typedef struct packed {
    logic [IdMaxW-1:0] id;
    logic [WordW-1:0]  data;
  } rsp_entry_t;

endpackage

// File: rtl/xpb_rsp_fifo.sv
// Two-entry in-order response buffer for xpb_lut_arbiter.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (clears pointers, count, storage)
//   push_i          write push_entry_i at the tail (caller guarantees not full)
//   push_entry_i    {id, data} entry to store
//   pop_i           drop the head entry (caller guarantees not empty)
//   head_o          oldest entry; all zero after reset
//   cnt_o           number of stored entries (0..2)
module xpb_rsp_fifo
  import xpb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  rsp_entry_t push_entry_i,
  input  logic       pop_i,
  output rsp_entry_t head_o,
  output logic [1:0] cnt_o
);

  rsp_entry_t mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/xpb_lut_arbiter.sv
// Round-robin sharing of one registered xpb lookup table among NumReq reduction lanes.
// One request is granted per cycle; the granted digit drives the table, the result arrives
// one cycle later and is buffered with its lane tag, and responses leave in issue order.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   req_valid_i     per-lane request valid
//   req_digit_i     per-lane digit, lane i at [i*DigitW +: DigitW]
//   req_ready_o     per-lane grant, at most one bit high
//   lut_digit_o     table address (granted digit, else 0)
//   lut_data_i      table output, one cycle after lut_digit_o
//   rsp_valid_o     response available
//   rsp_ready_i     consumer accepts the response
//   rsp_id_o        lane index of the response
//   rsp_data_o      looked-up value
module xpb_lut_arbiter
  import xpb_pkg::*;
#(
  parameter int unsigned NumReq = NumReqDefault,
  parameter int unsigned IdW    = $clog2(NumReq)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_valid_i,
  input  logic [NumReq*DigitW-1:0] req_digit_i,
  output logic [NumReq-1:0]        req_ready_o,
  output logic [DigitW-1:0]        lut_digit_o,
  input  logic [WordW-1:0]         lut_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [IdW-1:0]           rsp_id_o,
  output logic [WordW-1:0]         rsp_data_o
);

  logic [DigitW-1:0] lane_digit [NumReq];

  for (genvar i = 0; i < NumReq; i++) begin : g_lane
    assign lane_digit[i] = req_digit_i[i*DigitW +: DigitW];
  end

  logic [IdW-1:0]    last_q, last_d;
  logic              inflight_q;
  logic [IdW-1:0]    inflight_id_q;

  logic [1:0]        fifo_cnt;
  rsp_entry_t        fifo_head, push_entry;
  logic              pop, permit, found, accept;
  logic [2:0]        occ;
  int unsigned       cand;
  logic [IdW-1:0]    cand_idx, gnt_idx;
  logic [NumReq-1:0] gnt_oh;
  logic [DigitW-1:0] gnt_digit;

  // First valid lane starting just after the last accepted one.
  always_comb begin
    found     = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    gnt_digit = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = 32'(last_q) + 1 + k;
      if (cand >= NumReq) cand = cand - NumReq;
      cand_idx = IdW'(cand);
      if (!found && req_valid_i[cand_idx]) begin
        found            = 1'b1;
        gnt_idx          = cand_idx;
        gnt_oh[cand_idx] = 1'b1;
        gnt_digit        = lane_digit[cand_idx];
      end
    end
  end

  assign pop = rsp_valid_o & rsp_ready_i;

  // Buffered plus in-flight entries after this cycle's pop must leave room for one more.
  // Gating with rst_ni keeps req_ready low for the whole time reset is held.
  always_comb begin
    occ    = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    permit = rst_ni && (occ < 3'(RspDepth));
    accept = found & permit;
    last_d = accept ? gnt_idx : last_q;
  end

  assign req_ready_o = permit ? gnt_oh : '0;
  assign lut_digit_o = accept ? gnt_digit : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q        <= IdW'(NumReq - 1);
      inflight_q    <= 1'b0;
      inflight_id_q <= '0;
    end else begin
      last_q        <= last_d;
      inflight_q    <= accept;
      inflight_id_q <= gnt_idx;
    end
  end

  assign push_entry.id   = IdMaxW'(inflight_id_q);
  assign push_entry.data = lut_data_i;

  xpb_rsp_fifo u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (inflight_q),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (fifo_head),
    .cnt_o        (fifo_cnt)
  );

  assign rsp_valid_o = (fifo_cnt != 2'd0);
  assign rsp_id_o    = IdW'(fifo_head.id);
  assign rsp_data_o  = fifo_head.data;

endmodule
